// File: rtl/vedic_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mult_seq_if
// Brief    : Operand/product valid-ready bundle for vedic_mult_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface vedic_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/vedic_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mult_seq
// Brief    : Digit-serial WIDTHxWIDTH multiplier around one 4x4 Urdhva core;
//            define VEDIC_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
module vedic_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mult_seq_if.slave  bus
);
    localparam int D  = WIDTH / 4;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     i_q, i_d, j_q, j_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
`ifdef VEDIC_SIGNED_EN
    logic              sign_q, sign_d;
`endif

    logic [3:0]        dig_a, dig_b;
    logic [2:0]        col [7];
    logic [7:0]        pp;
    logic [CW+2:0]     shamt;
    logic [PW-1:0]     pp_ext, sum;

    // Urdhva-Tiryagbhyam: vertical/crosswise bit products summed per column.
    always_comb begin
        dig_a = a_q[{i_q, 2'b00} +: 4];
        dig_b = b_q[{j_q, 2'b00} +: 4];
        for (int k = 0; k < 7; k++) col[k] = '0;
        for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++)
                col[m+n] = col[m+n] + {2'b00, dig_a[m] & dig_b[n]};
        pp = '0;
        for (int k = 0; k < 7; k++)
            pp = pp + ({5'b00000, col[k]} << k);
        shamt  = ({3'b000, i_q} + {3'b000, j_q}) << 2;
        pp_ext = PW'(pp) << shamt;
        sum    = acc_q + pp_ext;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
`ifdef VEDIC_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_BUSY;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
`ifdef VEDIC_SIGNED_EN
                    // -(-2^(WIDTH-1)) wraps to itself, which is the right unsigned magnitude.
                    a_d    = bus.a[WIDTH-1] ? -bus.a : bus.a;
                    b_d    = bus.b[WIDTH-1] ? -bus.b : bus.b;
                    sign_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
                    a_d = bus.a;
                    b_d = bus.b;
`endif
                end
            end
            S_BUSY: begin
                acc_d = sum;
                if (j_q == CW'(D - 1)) begin
                    j_d = '0;
                    if (i_q == CW'(D - 1)) begin
                        state_d = S_DONE;
`ifdef VEDIC_SIGNED_EN
                        acc_d = sign_q ? -sum : sum;
`endif
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d == S_BUSY);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef VEDIC_SIGNED_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef VEDIC_SIGNED_EN
            sign_q      <= sign_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = acc_q;
endmodule
`default_nettype wire

// File: tb/tb_vedic_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_mult_seq
// Brief    : Directed self-checking bench for vedic_mult_seq at WIDTH 4/8/16;
//            signed vectors run when VEDIC_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vedic_mult_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vedic_mult_seq_if #(.WIDTH(4))  bus4  ();
    vedic_mult_seq_if #(.WIDTH(8))  bus8  ();
    vedic_mult_seq_if #(.WIDTH(16)) bus16 ();

    vedic_mult_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    vedic_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    vedic_mult_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Latency counts the accept edge as 1; returns at first cycle with out_valid high.
    task automatic wait_valid8(output int lat);
        lat = 1;
        while (bus8.out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output int lat);
        bus8.a = a; bus8.b = b; bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0; bus8.a = ~a; bus8.b = ~b;
        wait_valid8(lat);
        prod = bus8.product;
        @(posedge clk); #1;
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] prod, output int lat);
        bus4.a = a; bus4.b = b; bus4.out_ready = 1'b1; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0; bus4.a = ~a; bus4.b = ~b;
        lat = 1;
        while (bus4.out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        prod = bus4.product;
        @(posedge clk); #1;
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] prod, output int lat);
        bus16.a = a; bus16.b = b; bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0; bus16.a = ~a; bus16.b = ~b;
        lat = 1;
        while (bus16.out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        prod = bus16.product;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus8.busy); end
        checks++; if (bus8.product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", bus8.product); end
        checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_w4 got=%b exp=1", bus4.in_ready); end
        checks++; if (bus16.product !== 32'h0) begin errors++; $display("FAIL reset_product_w16 got=%h exp=0", bus16.product); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] p; int lat;
        do_op8(8'd5, 8'd2, p, lat);
        checks++; if (p !== 16'h000A) begin errors++; $display("FAIL basic_5x2 got=%h exp=000a", p); end
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_5x2_latency got=%0d exp=5", lat); end
        do_op8(8'hFF, 8'hFF, p, lat);
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL basic_ffxff got=%h exp=fe01", p); end
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_ffxff_latency got=%0d exp=5", lat); end
        do_op8(8'h12, 8'h34, p, lat);
        checks++; if (p !== 16'h03A8) begin errors++; $display("FAIL basic_12x34 got=%h exp=03a8", p); end
    endtask

    task automatic test_zero_identity();
        logic [15:0] p; int lat;
        do_op8(8'h00, 8'hA5, p, lat);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_x_a5 got=%h exp=0000", p); end
        checks++; if (lat != 5) begin errors++; $display("FAIL zero_latency got=%0d exp=5", lat); end
        do_op8(8'h01, 8'hA5, p, lat);
        checks++; if (p !== 16'h00A5) begin errors++; $display("FAIL one_x_a5 got=%h exp=00a5", p); end
        checks++; if (lat != 5) begin errors++; $display("FAIL one_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_backpressure();
        int lat;
        bus8.a = 8'd3; bus8.b = 8'd4; bus8.out_ready = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        wait_valid8(lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency got=%0d exp=5", lat); end
        checks++; if (bus8.product !== 16'h000C) begin errors++; $display("FAIL bp_product got=%h exp=000c", bus8.product); end
        bus8.a = 8'd7; bus8.b = 8'd6; bus8.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, bus8.out_valid); end
            checks++; if (bus8.product !== 16'h000C) begin errors++; $display("FAIL bp_hold_product cyc=%0d got=%h exp=000c", c, bus8.product); end
            checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", c, bus8.in_ready); end
        end
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", bus8.out_valid); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", bus8.in_ready); end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL bp_second_busy got=%b exp=1", bus8.busy); end
        wait_valid8(lat);
        checks++; if (bus8.product !== 16'h002A) begin errors++; $display("FAIL bp_second_product got=%h exp=002a", bus8.product); end
        checks++; if (lat != 5) begin errors++; $display("FAIL bp_second_latency got=%0d exp=5", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; int lat;
        bus8.a = 8'd9; bus8.b = 8'd9; bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", bus8.out_valid); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus8.busy); end
        checks++; if (bus8.product !== 16'h0000) begin errors++; $display("FAIL midrst_product got=%h exp=0000", bus8.product); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", bus8.in_ready); end
        do_op8(8'd9, 8'd9, p, lat);
        checks++; if (p !== 16'h0051) begin errors++; $display("FAIL midrst_retry got=%h exp=0051", p); end
        checks++; if (lat != 5) begin errors++; $display("FAIL midrst_retry_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_w4();
        logic [7:0] p; logic [7:0] exp; int lat;
        do_op4(4'hF, 4'hF, p, lat);
        checks++; if (p !== 8'hE1) begin errors++; $display("FAIL w4_fxf got=%h exp=e1", p); end
        checks++; if (lat != 2) begin errors++; $display("FAIL w4_latency got=%0d exp=2", lat); end
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                exp = 8'(x * y);
                do_op4(4'(x), 4'(y), p, lat);
                checks++; if (p !== exp) begin errors++; $display("FAIL w4_sweep a=%0d b=%0d got=%h exp=%h", x, y, p, exp); end
            end
        end
    endtask

    task automatic test_w16();
        logic [31:0] p; logic [31:0] exp; logic [15:0] ra, rb; int lat;
        do_op16(16'hFFFF, 16'hFFFF, p, lat);
        checks++; if (p !== 32'hFFFE0001) begin errors++; $display("FAIL w16_max got=%h exp=fffe0001", p); end
        checks++; if (lat != 17) begin errors++; $display("FAIL w16_latency got=%0d exp=17", lat); end
        do_op16(16'h1234, 16'h5678, p, lat);
        checks++; if (p !== 32'h06260060) begin errors++; $display("FAIL w16_1234x5678 got=%h exp=06260060", p); end
        for (int n = 0; n < 8; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            exp = {16'h0, ra} * {16'h0, rb};
            do_op16(ra, rb, p, lat);
            checks++; if (p !== exp) begin errors++; $display("FAIL w16_random a=%h b=%h got=%h exp=%h", ra, rb, p, exp); end
        end
    endtask

    task automatic test_signed();
        logic [15:0] p; int lat;
        do_op8(8'h80, 8'h80, p, lat);
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL signed_m128xm128 got=%h exp=4000", p); end
        checks++; if (lat != 5) begin errors++; $display("FAIL signed_latency got=%0d exp=5", lat); end
        do_op8(8'hFF, 8'h01, p, lat);
        checks++; if (p !== 16'hFFFF) begin errors++; $display("FAIL signed_m1x1 got=%h exp=ffff", p); end
        do_op8(8'hF9, 8'h03, p, lat);
        checks++; if (p !== 16'hFFEB) begin errors++; $display("FAIL signed_m7x3 got=%h exp=ffeb", p); end
        do_op8(8'h00, 8'hFB, p, lat);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL signed_0xm5 got=%h exp=0000", p); end
        do_op8(8'h01, 8'hA5, p, lat);
        checks++; if (p !== 16'hFFA5) begin errors++; $display("FAIL signed_1xa5 got=%h exp=ffa5", p); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus4.in_valid = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b0;
        test_reset();
`ifdef VEDIC_SIGNED_EN
        test_signed();
`else
        test_basic();
        test_zero_identity();
        test_w4();
        test_w16();
`endif
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
